// File: rtl/first_one_iterator_if.sv
// Handshake bundle between a mask producer, the first-one iterator and an
// index consumer. Signal names keep the iterator's port-level direction suffixes.
interface first_one_iterator_if #(
  parameter int WIDTH = 8
) ();
  localparam int IDX_W = $clog2(WIDTH);

  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_mask_i;
  logic             idx_valid_o;
  logic             idx_ready_i;
  logic [IDX_W-1:0] idx_o;
  logic             idx_last_o;

  // Iterator side: consumes masks, produces indices.
  modport slave (
    input  in_valid_i,
    input  in_mask_i,
    input  idx_ready_i,
    output in_ready_o,
    output idx_valid_o,
    output idx_o,
    output idx_last_o
  );

  // Environment side: offers masks, accepts indices.
  modport master (
    output in_valid_i,
    output in_mask_i,
    output idx_ready_i,
    input  in_ready_o,
    input  idx_valid_o,
    input  idx_o,
    input  idx_last_o
  );
endinterface

// File: rtl/first_one_iterator.sv
// Streams out the index of every set bit of an accepted mask, lowest first
// (or highest first with FLIP=1), clearing each bit as its index is taken.
module first_one_iterator #(
  parameter int WIDTH = 8,
  parameter bit FLIP  = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  first_one_iterator_if.slave        bus,
  output logic                       empty_drop_o,
  output logic                       busy_o,
  output logic [$clog2(WIDTH+1)-1:0] remaining_o
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH+1);

  if (WIDTH < 2) begin : g_width_check
    $error("first_one_iterator: WIDTH must be >= 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mask_q,  mask_d;
  logic             empty_q, empty_d;

  logic [IDX_W-1:0] first_idx;
  logic [CNT_W-1:0] pop_cnt;
  logic             last;
  logic             in_hs;
  logic             idx_hs;
  logic             flush;

  // Position of the first set bit in emission order; 0 for an empty mask.
  function automatic logic [IDX_W-1:0] first_set(input logic [WIDTH-1:0] m);
    logic [IDX_W-1:0] pos;
    pos = '0;
    if (!FLIP) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (m[i]) pos = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (m[i]) pos = IDX_W'(i);
      end
    end
    return pos;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] m);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CNT_W'(m[i]);
    end
    return cnt;
  endfunction

  assign first_idx = first_set(mask_q);
  assign pop_cnt   = popcount(mask_q);

  // While reset is asserted flush is ignored so in_ready_o shows its reset value.
  assign flush = flush_i & rst_ni;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d           = state_q;
    mask_d            = mask_q;
    empty_d           = 1'b0;
    bus.in_ready_o    = 1'b0;
    bus.idx_valid_o   = 1'b0;
    bus.idx_o         = '0;
    bus.idx_last_o    = 1'b0;
    busy_o            = 1'b0;
    remaining_o       = '0;
    last              = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.in_ready_o = !flush;
      end
      ITER: begin
        last            = (pop_cnt == CNT_W'(1));
        bus.idx_valid_o = 1'b1;
        bus.idx_o       = first_idx;
        bus.idx_last_o  = last;
        busy_o          = 1'b1;
        remaining_o     = pop_cnt;
        // A new mask may only slip in alongside the final index handshake.
        bus.in_ready_o  = bus.idx_ready_i && last && !flush;
      end
      default: begin
        state_d = IDLE;
        mask_d  = '0;
      end
    endcase

    idx_hs = bus.idx_valid_o && bus.idx_ready_i;
    in_hs  = bus.in_valid_i && bus.in_ready_o;

    if (flush) begin
      state_d = IDLE;
      mask_d  = '0;
    end else begin
      if (idx_hs) begin
        mask_d = mask_q & ~({{(WIDTH-1){1'b0}}, 1'b1} << first_idx);
        if (last) state_d = IDLE;
      end
      if (in_hs) begin
        if (bus.in_mask_i != '0) begin
          mask_d  = bus.in_mask_i;
          state_d = ITER;
        end else begin
          empty_d = 1'b1;
          state_d = IDLE;
        end
      end
    end
  end

  assign empty_drop_o = empty_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mask_q  <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      empty_q <= empty_d;
    end
  end
endmodule

// File: tb/tb_first_one_iterator.sv
// Self-checking bench: two iterators (LSB-first and MSB-first) share stimulus
// and are compared against a queue-of-positions reference model.
module tb_first_one_iterator;
  localparam int WIDTH = 8;
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH+1);

  logic clk_i;
  logic rst_ni;
  logic flush_i;

  logic             empty0, empty1;
  logic             busy0,  busy1;
  logic [CNT_W-1:0] rem0,   rem1;

  int total;
  int bad;

  // Reference: pending indices in emission order for each ordering.
  int  q_lo[$];
  int  q_hi[$];
  bit  exp_empty;

  first_one_iterator_if #(.WIDTH(WIDTH)) bus0 ();
  first_one_iterator_if #(.WIDTH(WIDTH)) bus1 ();

  first_one_iterator #(.WIDTH(WIDTH), .FLIP(1'b0)) dut_lo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .bus          (bus0),
    .empty_drop_o (empty0),
    .busy_o       (busy0),
    .remaining_o  (rem0)
  );

  first_one_iterator #(.WIDTH(WIDTH), .FLIP(1'b1)) dut_hi (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .bus          (bus1),
    .empty_drop_o (empty1),
    .busy_o       (busy1),
    .remaining_o  (rem1)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [WIDTH-1:0] m, input bit rdy, input bit fl);
    bus0.in_valid_i  = v;
    bus0.in_mask_i   = m;
    bus0.idx_ready_i = rdy;
    bus1.in_valid_i  = v;
    bus1.in_mask_i   = m;
    bus1.idx_ready_i = rdy;
    flush_i          = fl;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus0.idx_valid_o), 0);
    check({tag, "_idx"},   32'(bus0.idx_o), 0);
    check({tag, "_last"},  32'(bus0.idx_last_o), 0);
    check({tag, "_busy"},  32'(busy0), 0);
    check({tag, "_rem"},   32'(rem0), 0);
    check({tag, "_empty"}, 32'(empty0), 0);
    check({tag, "_ready"}, 32'(bus0.in_ready_o), 1);
    check({tag, "_hi_valid"}, 32'(bus1.idx_valid_o), 0);
    check({tag, "_hi_ready"}, 32'(bus1.in_ready_o), 1);
  endtask

  // One clock: drive inputs at the falling edge, compare against the model,
  // then advance the model to what the next rising edge should produce.
  task automatic step(input bit v, input logic [WIDTH-1:0] m, input bit rdy, input bit fl);
    int  n;
    bit  exp_ready;
    @(negedge clk_i);
    drive(v, m, rdy, fl);
    #1;
    n = q_lo.size();
    exp_ready = (n == 0) ? !fl : (rdy && n == 1 && !fl);

    check("idx_valid",  32'(bus0.idx_valid_o), 32'(n > 0));
    check("busy",       32'(busy0),            32'(n > 0));
    check("remaining",  32'(rem0),             32'(n));
    check("idx_last",   32'(bus0.idx_last_o),  32'(n == 1));
    check("idx_lo",     32'(bus0.idx_o),       (n > 0) ? 32'(q_lo[0]) : 0);
    check("idx_hi",     32'(bus1.idx_o),       (n > 0) ? 32'(q_hi[0]) : 0);
    check("in_ready",   32'(bus0.in_ready_o),  32'(exp_ready));
    check("empty_drop", 32'(empty0),           32'(exp_empty));
    check("hi_valid",   32'(bus1.idx_valid_o), 32'(n > 0));
    check("hi_rem",     32'(rem1),             32'(n));
    check("hi_empty",   32'(empty1),           32'(exp_empty));

    exp_empty = 1'b0;
    if (fl) begin
      q_lo.delete();
      q_hi.delete();
    end else begin
      if (n > 0 && rdy) begin
        void'(q_lo.pop_front());
        void'(q_hi.pop_front());
      end
      if (v && exp_ready) begin
        if (m == '0) begin
          exp_empty = 1'b1;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (m[i]) begin
              q_lo.push_back(i);
              q_hi.push_front(i);
            end
          end
        end
      end
    end
  endtask

  initial begin
    logic [WIDTH-1:0] m;
    total     = 0;
    bad       = 0;
    exp_empty = 1'b0;

    drive(1'b1, 8'hA5, 1'b1, 1'b1);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("reset");
    #20;
    @(negedge clk_i);
    drive(1'b0, '0, 1'b0, 1'b0);
    rst_ni = 1'b1;

    // Basic iteration, both orders: lo emits 2,5,7; hi emits 7,5,2.
    step(1, 8'b1010_0100, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    // Backpressure: index and remaining hold while ready is low.
    step(1, 8'h81, 0, 0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    // Back-to-back: second mask accepted with the last index handshake.
    step(1, 8'h01, 1, 0);
    step(1, 8'h0C, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    // Zero mask is dropped with a single-cycle pulse.
    step(1, 8'h00, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    // Back-to-back into a zero mask.
    step(1, 8'h40, 1, 0);
    step(1, 8'h00, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    // Flush after two handshakes of an all-ones mask.
    step(1, 8'hFF, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    step(1, 8'h3C, 1, 1);
    step(0, '0, 1, 0);

    // Asynchronous reset in the middle of a stream.
    step(1, 8'hF0, 1, 0);
    step(0, '0, 0, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("midreset");
    q_lo.delete();
    q_hi.delete();
    exp_empty = 1'b0;
    @(negedge clk_i);
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      m = WIDTH'($urandom);
      if ($urandom_range(5) == 0) m = '0;
      step(bit'($urandom_range(1)), m, ($urandom_range(9) < 7), ($urandom_range(24) == 0));
    end
    for (int k = 0; k < 12; k++) step(0, '0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
